wb_ram_stream_reader: RTL and testbench
=======================================

Name: wb_ram_stream_reader

Overview:
- Wishbone master that streams a block of words out of the OpenRAM wrapper through its read-only Wishbone port, directly upstream of that wrapper's wbs1 port.
- Firmware or a control block supplies start word address and word count; the block issues one single-word read at a time.
- Read data is buffered in a small FIFO and presented to a downstream consumer on a valid/ready stream interface.
- Consumer backpressure throttles the Wishbone requests.

Parameters:
- BASE_ADDR, 32'h3000_0000, base OR-ed into every issued address; must match the wrapper's base for the port.
- ADDR_WIDTH, 8, RAM word-address width; the wrapper uses adr[ADDR_WIDTH-1:0] as the RAM word address.
- FIFO_DEPTH, 4, stream FIFO entries; power of 2, at least 2.
- ACK_TIMEOUT, 16, cycles allowed from stb assertion to ack before the transfer is failed; at least 2.

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start pulse; sampled only in IDLE.
- start_addr_i  in  ADDR_WIDTH  first RAM word address.
- word_count_i  in  ADDR_WIDTH+1  number of words; 0 is legal.
- abort_i  in  1  cancel the current transfer.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies done_o; high means the transfer timed out.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  tied 0.
- wbm_sel_o  out  4  tied 4'hF.
- wbm_adr_o  out  32  BASE_ADDR | word address in bits [ADDR_WIDTH-1:0].
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.
- stream_valid_o  out  1  FIFO not empty.
- stream_data_o  out  32  FIFO head (first-word-fall-through).
- stream_ready_i  in  1  consumer pop when stream_valid_o is high.

Behaviour:
- Reset (async) clears all of the following, and all outputs are registered:
  - Outputs: cyc, stb, busy, done, err, stream_valid go to 0; adr goes to BASE_ADDR.
  - Internal: FIFO empties, FSM goes to IDLE, counters clear.
- FSM states:
  - IDLE: start_i latches address and count. A count of 0 goes to DONE; otherwise go to REQ.
  - REQ: cyc=1, stb=1, adr held.
    - On ack: push wbm_dat_i into the FIFO, increment the address, decrement the count, go to GAP.
    - If the timeout counter reaches ACK_TIMEOUT-1 with no ack: go to DONE with err=1.
  - GAP: stb=0, cyc=1, one cycle.
    - Count 0 goes to DONE.
    - FIFO occupancy below FIFO_DEPTH goes to REQ.
    - Otherwise go to WAIT.
  - WAIT: stb=0, cyc=1; go to REQ once the FIFO has a free slot.
  - DONE: one cycle with done_o=1, cyc=0, busy=0; err_o is valid in this cycle only. Then go to IDLE.
- Timing:
  - start at cycle 0 gives cyc/stb high at cycle 1.
  - ack at cycle k gives data visible on stream_valid_o/stream_data_o at k+1 and next stb at k+2 at the earliest.
  - After the last ack at cycle k, done_o fires at k+2.
- busy_o is 1 in REQ, GAP and WAIT only.
- At most one request is outstanding. A request is issued only if the FIFO has a free slot, so a push never hits a full FIFO.
- The timeout counter clears each time REQ is entered.
- Address arithmetic is modulo 2^ADDR_WIDTH: after the all-ones address comes 0. Upper address bits always come from BASE_ADDR.
- FIFO:
  - Pop happens when stream_valid_o && stream_ready_i.
  - Simultaneous push and pop keeps occupancy unchanged.
  - The FIFO survives DONE; remaining words drain after done_o.
- start_i outside IDLE is ignored; start_i in the DONE cycle is also ignored.
- abort_i (any non-IDLE state, including REQ mid-wait):
  - Next cycle cyc=stb=0 and the FSM returns to IDLE.
  - An ack coinciding with abort is discarded.
  - The FIFO is flushed; no done_o pulse.
- wbm_ack_i outside REQ is ignored.

Decomposition:
- Shared package (wb_openram_pkg) holds:
  - the FSM state enum: IDLE, REQ, GAP, WAIT, DONE;
  - the WB_SEL_ALL = 4'hF constant.
- One sub-module, sync_fifo: parameterised width/depth, first-word-fall-through, with push, pop, flush, count, full and empty.

Test Plan:
- Reset mid-transfer:
  - Stimulus: assert wb_rst_i while stb is high.
  - Response: all outputs 0 and adr = 32'h3000_0000 asynchronously; the FIFO is empty after release.
- Basic 3-word read:
  - Stimulus: start_addr 8'h10, count 3, slave acks 1 cycle after stb with data = {24'hA5A5A5, adr[7:0]}, ready=1.
  - Response: adr 3000_0010/11/12; stream emits A5A5A510, A5A5A511, A5A5A512 in order; done=1, err=0 two cycles after the last ack.
- Backpressure:
  - Stimulus: count 6, ready=0.
  - Response: exactly 4 acks, then cyc stays high with stb low. After raising ready, the remaining 2 reads complete, 6 words are delivered in order, and none are lost or duplicated.
- Address wrap:
  - Stimulus: start_addr 8'hFE, count 4.
  - Response: adr low bytes FE, FF, 00, 01.
- Zero count:
  - Stimulus: count 0.
  - Response: done=1 at cycle 1; cyc never asserted.
- Timeout and abort:
  - Stimulus A: slave never acks.
  - Response A: stb drops after 16 cycles; done=1 and err=1 for one cycle.
  - Stimulus B: repeat, then pulse abort_i in cycle 5 of REQ.
  - Response B: cyc=0 next cycle, no done, FIFO empty.

Source files
------------

// File: rtl/wb_openram_pkg.sv
// rtl/wb_openram_pkg.sv - shared types and constants for the OpenRAM Wishbone stream reader
package wb_openram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_ram_stream_reader_if.sv
// rtl/wb_ram_stream_reader_if.sv - Wishbone read master bus plus outbound word stream
interface wb_ram_stream_reader_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        stream_valid_o;
  logic [31:0] stream_data_o;
  logic        stream_ready_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
    input  wbm_ack_i, wbm_dat_i,
    output stream_valid_o, stream_data_o,
    input  stream_ready_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
    output wbm_ack_i, wbm_dat_i,
    input  stream_valid_o, stream_data_o,
    output stream_ready_i
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_ram_stream_reader.sv
// rtl/wb_ram_stream_reader.sv - single-word Wishbone reader streaming an OpenRAM block out through a FIFO
module wb_ram_stream_reader
  import wb_openram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  wb_ram_stream_reader_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [TW-1:0]         tmo_q;
  logic                  in_req;
  logic                  ack_ok;
  logic                  timed_out;
  logic                  aborting;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign in_req    = (state_q == REQ);
  assign aborting  = abort_i && (state_q != IDLE);
  // An ack arriving together with abort is dropped along with the transfer.
  assign ack_ok    = in_req && bus.wbm_ack_i && !abort_i;
  assign timed_out = in_req && !bus.wbm_ack_i && (tmo_q == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = (word_count_i == '0) ? DONE : REQ;
      REQ: begin
        if (bus.wbm_ack_i)  state_d = GAP;
        else if (timed_out) state_d = DONE;
      end
      GAP: begin
        if (cnt_q == '0)                     state_d = DONE;
        else if (fifo_count < CW'(FIFO_DEPTH)) state_d = REQ;
        else                                 state_d = WAIT;
      end
      WAIT:    if (!fifo_full) state_d = REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (aborting) state_d = IDLE;
  end

  // Outputs are registered off the next state so they line up with it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      bus.wbm_cyc_o <= (state_d == REQ) || (state_d == GAP) || (state_d == WAIT);
      bus.wbm_stb_o <= (state_d == REQ);
      busy_o        <= (state_d == REQ) || (state_d == GAP) || (state_d == WAIT);
      done_o        <= (state_d == DONE);
      err_o         <= (state_d == DONE) && timed_out;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      addr_q <= '0;
      cnt_q  <= '0;
      tmo_q  <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        addr_q <= start_addr_i;
        cnt_q  <= word_count_i;
      end else if (ack_ok) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
      if (state_d == REQ && !in_req) tmo_q <= '0;
      else if (in_req)               tmo_q <= tmo_q + 1'b1;
    end
  end

  assign bus.wbm_adr_o      = BASE_ADDR | 32'(addr_q);
  assign bus.wbm_we_o       = 1'b0;
  assign bus.wbm_sel_o      = WB_SEL_ALL;
  assign bus.stream_valid_o = !fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (ack_ok),
    .push_data (bus.wbm_dat_i),
    .pop       (bus.stream_valid_o && bus.stream_ready_i),
    .flush     (aborting),
    .head      (bus.stream_data_o),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_wb_ram_stream_reader.sv
// tb/tb_wb_ram_stream_reader.sv - directed self-checking bench for wb_ram_stream_reader
module tb_wb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] word_count;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;
  logic       slave_en;
  bit         prev_stb;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int s_cyc;

  logic [31:0] ack_adr[$];
  int          ack_cyc[$];
  logic [31:0] rx[$];
  int          first_valid;
  int          n_acks;
  int          n_done;
  int          done_cyc;
  logic        done_err;
  int          n_cyc_hi;
  int          n_stb;

  wb_ram_stream_reader_if bus();

  wb_ram_stream_reader dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .word_count_i (word_count),
    .abort_i      (abort),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  // Slave answers one cycle after it first sees stb.
  always @(posedge clk) begin
    #2;
    bus.wbm_ack_i = slave_en && bus.wbm_stb_o && prev_stb;
    prev_stb      = bus.wbm_stb_o && !bus.wbm_ack_i;
    bus.wbm_dat_i = {24'hA5A5A5, bus.wbm_adr_o[7:0]};
  end

  always @(negedge clk) begin
    if (bus.wbm_ack_i && bus.wbm_stb_o) begin
      ack_adr.push_back(bus.wbm_adr_o);
      ack_cyc.push_back(cyc_n);
      n_acks++;
    end
    if (bus.stream_valid_o && bus.stream_ready_i) rx.push_back(bus.stream_data_o);
    if (bus.stream_valid_o && first_valid < 0) first_valid = cyc_n;
    if (done) begin
      n_done++;
      done_cyc = cyc_n;
      done_err = err;
    end
    if (bus.wbm_cyc_o) n_cyc_hi++;
    if (bus.wbm_stb_o) n_stb++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_mon();
    ack_adr.delete();
    ack_cyc.delete();
    rx.delete();
    first_valid = -1;
    n_acks = 0;
    n_done = 0;
    done_cyc = -1;
    done_err = 1'bx;
    n_cyc_hi = 0;
    n_stb = 0;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [8:0] c);
    clear_mon();
    start_addr = a;
    word_count = c;
    start = 1'b1;
    s_cyc = cyc_n;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) step(1);
    check_eq("done_seen", 32'(n_done), 32'd1);
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx.size()) ? rx[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_wrap [4];
    exp_wrap = '{32'h3000_00FE, 32'h3000_00FF, 32'h3000_0000, 32'h3000_0001};
    start = 0; start_addr = 0; word_count = 0; abort = 0;
    bus.stream_ready_i = 1'b1;
    slave_en = 1'b1;
    clear_mon();
    step(2);
    check_eq("rst_cyc", 32'(bus.wbm_cyc_o), 0);
    check_eq("rst_stb", 32'(bus.wbm_stb_o), 0);
    check_eq("rst_busy_done_err", {29'd0, busy, done, err}, 0);
    check_eq("rst_valid", 32'(bus.stream_valid_o), 0);
    check_eq("rst_adr", bus.wbm_adr_o, 32'h3000_0000);
    check_eq("tie_sel_we", {27'd0, bus.wbm_sel_o, bus.wbm_we_o}, 32'h1E);
    rst = 1'b0;
    step(2);

    // Basic 3-word read
    do_start(8'h10, 9'd3);
    check_eq("basic_stb_c1", 32'(bus.wbm_stb_o), 1);
    check_eq("basic_adr_c1", bus.wbm_adr_o, 32'h3000_0010);
    wait_done(30);
    check_eq("basic_done_lat", 32'(done_cyc - ack_cyc[$]), 2);
    check_eq("basic_err", 32'(done_err), 0);
    check_eq("basic_valid_lat", 32'(first_valid - ack_cyc[0]), 1);
    step(3);
    check_eq("basic_nacks", 32'(n_acks), 3);
    check_eq("basic_rx_n", 32'(rx.size()), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("basic_adr", (i < ack_adr.size()) ? ack_adr[i] : 32'hDEAD_BEEF, 32'h3000_0010 + 32'(i));
      check_eq("basic_rx", rx_at(i), 32'hA5A5_A510 + 32'(i));
    end

    // Backpressure
    bus.stream_ready_i = 1'b0;
    do_start(8'h20, 9'd6);
    step(30);
    check_eq("bp_nacks4", 32'(n_acks), 4);
    check_eq("bp_cyc", 32'(bus.wbm_cyc_o), 1);
    check_eq("bp_stb", 32'(bus.wbm_stb_o), 0);
    check_eq("bp_busy", 32'(busy), 1);
    check_eq("bp_head", bus.stream_data_o, 32'hA5A5_A520);
    bus.stream_ready_i = 1'b1;
    wait_done(40);
    check_eq("bp_err", 32'(done_err), 0);
    step(4);
    check_eq("bp_nacks6", 32'(n_acks), 6);
    check_eq("bp_rx_n", 32'(rx.size()), 6);
    for (int i = 0; i < 6; i++) check_eq("bp_rx", rx_at(i), 32'hA5A5_A520 + 32'(i));
    check_eq("bp_drained", 32'(bus.stream_valid_o), 0);

    // Address wrap
    do_start(8'hFE, 9'd4);
    wait_done(40);
    step(3);
    for (int i = 0; i < 4; i++)
      check_eq("wrap_adr", (i < ack_adr.size()) ? ack_adr[i] : 32'hDEAD_BEEF, exp_wrap[i]);
    check_eq("wrap_rx3", rx_at(3), 32'hA5A5_A501);

    // Zero count
    do_start(8'h33, 9'd0);
    check_eq("zero_done_live", 32'(done), 1);
    step(3);
    check_eq("zero_done_cyc", 32'(done_cyc - s_cyc), 1);
    check_eq("zero_ndone", 32'(n_done), 1);
    check_eq("zero_no_cyc", 32'(n_cyc_hi), 0);
    check_eq("zero_err", 32'(done_err), 0);

    // Timeout
    slave_en = 1'b0;
    do_start(8'h40, 9'd2);
    wait_done(40);
    check_eq("tmo_done_cyc", 32'(done_cyc - s_cyc), 17);
    check_eq("tmo_err", 32'(done_err), 1);
    check_eq("tmo_nstb", 32'(n_stb), 16);
    step(2);
    check_eq("tmo_ndone", 32'(n_done), 1);
    check_eq("tmo_err_cleared", 32'(err), 0);
    check_eq("tmo_cyc_low", 32'(bus.wbm_cyc_o), 0);

    // Abort in cycle 5 of REQ with no slave
    do_start(8'h40, 9'd2);
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_eq("abort_cyc", 32'(bus.wbm_cyc_o), 0);
    check_eq("abort_stb", 32'(bus.wbm_stb_o), 0);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_valid", 32'(bus.stream_valid_o), 0);
    step(5);
    check_eq("abort_ndone", 32'(n_done), 0);

    // Abort with words buffered: FIFO must flush
    slave_en = 1'b1;
    bus.stream_ready_i = 1'b0;
    do_start(8'h50, 9'd6);
    for (int i = 0; i < 20 && n_acks < 2; i++) step(1);
    check_eq("flush_pre_valid", 32'(bus.stream_valid_o), 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_eq("flush_valid", 32'(bus.stream_valid_o), 0);
    check_eq("flush_cyc", 32'(bus.wbm_cyc_o), 0);
    step(3);
    check_eq("flush_ndone", 32'(n_done), 0);

    // Reset mid-transfer while stb is high with data buffered
    do_start(8'h60, 9'd5);
    for (int i = 0; i < 20 && !(n_acks >= 1 && bus.wbm_stb_o); i++) step(1);
    check_eq("mrst_pre_stb", 32'(bus.wbm_stb_o), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("mrst_cyc_stb", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    check_eq("mrst_busy_done_err", {29'd0, busy, done, err}, 0);
    check_eq("mrst_valid", 32'(bus.stream_valid_o), 0);
    check_eq("mrst_adr", bus.wbm_adr_o, 32'h3000_0000);
    step(1);
    rst = 1'b0;
    bus.stream_ready_i = 1'b1;
    step(2);
    check_eq("mrst_post_valid", 32'(bus.stream_valid_o), 0);
    check_eq("mrst_post_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
